// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory arbiter.
//   - FSM state encoding (ST_IDLE/ST_ISSUE/ST_DONE)
//   - requester ids (ID_FETCH/ID_DATA)
//   - STARVE_LIMIT default
//   - RISC-V load/store funct3 codes (LOAD_*, STORE_*)
//   - acc_t latched access record and access_err() legality check
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic ID_FETCH = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  // One in-flight access, captured at arbitration.
  typedef struct packed {
    logic        id;
    logic        we;
    logic        err;
    logic [2:0]  f3;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  // High for undefined funct3, misalignment, or an access running past byte 63.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [5:0] addr);
    logic [2:0] size_m1;
    logic       undef;
    logic       misalign;
    logic [6:0] last;
    size_m1 = 3'd0;
    undef   = 1'b0;
    if (we) begin
      case (f3)
        STORE_SB: size_m1 = 3'd0;
        STORE_SH: size_m1 = 3'd1;
        STORE_SW: size_m1 = 3'd3;
        default:  undef   = 1'b1;
      endcase
    end else begin
      case (f3)
        LOAD_LB, LOAD_LBU: size_m1 = 3'd0;
        LOAD_LH, LOAD_LHU: size_m1 = 3'd1;
        LOAD_LW:           size_m1 = 3'd3;
        default:           undef   = 1'b1;
      endcase
    end
    misalign = ((size_m1 == 3'd1) && addr[0]) || ((size_m1 == 3'd3) && (addr[1:0] != 2'b00));
    last     = {1'b0, addr} + {4'd0, size_m1};
    return undef || misalign || last[6];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and shared memory port of the arbiter.
//   slave  - arbiter view (requests in, acks/memory strobes out, mem_rdata in)
//   master - environment view (requesters and memory)
interface mem_arbiter_if;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_f3;
  logic [5:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_f3;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
    output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
           mem_rd, mem_wr, mem_f3, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
           mem_rd, mem_wr, mem_f3, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts data grants made while a fetch is waiting.
//   clk, rst_n     clock, async active-low reset
//   arb            an arbitration happens this cycle
//   grant_fetch    that arbitration picks the fetch port
//   fetch_pending  if_req at arbitration
//   starve         count has reached STARVE_LIMIT; fetch must win next
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb,
  input  logic grant_fetch,
  input  logic fetch_pending,
  output logic starve
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (arb) begin
      if (grant_fetch || !fetch_pending) begin
        cnt_d = '0;
      end else if (cnt_q != CW'(STARVE_LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve = (cnt_q == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a fetch port and a data port onto one memory port.
//   clk, rst_n   clock, async active-low reset
//   bus          mem_arbiter_if.slave: if_* fetch, d_* data, mem_* memory port
//   busy         high whenever the FSM is not idle
// One access in flight: IDLE (arbitrate+latch) -> ISSUE (drive memory) ->
// DONE (ack). Data wins over fetch. Build option ARB_STARVE_GUARD_EN forces a
// fetch grant after STARVE_LIMIT consecutive data grants while if_req waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  if (STARVE_LIMIT == 0) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  logic [1:0]  state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        any_req;
  logic        grant_fetch;
  logic        starve;

  assign any_req = bus.if_req | bus.d_req;

`ifdef ARB_STARVE_GUARD_EN
  logic arb;
  assign arb = (state_q == ST_IDLE) & any_req;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk           (clk),
    .rst_n         (rst_n),
    .arb           (arb),
    .grant_fetch   (grant_fetch),
    .fetch_pending (bus.if_req),
    .starve        (starve)
  );
`else
  assign starve = 1'b0;
`endif

  assign grant_fetch = bus.if_req & (~bus.d_req | starve);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          if (grant_fetch) begin
            acc_d.id    = ID_FETCH;
            acc_d.we    = 1'b0;
            acc_d.f3    = LOAD_LW;
            acc_d.addr  = bus.if_addr;
            acc_d.wdata = '0;
          end else begin
            acc_d.id    = ID_DATA;
            acc_d.we    = bus.d_we;
            acc_d.f3    = bus.d_f3;
            acc_d.addr  = bus.d_addr;
            acc_d.wdata = bus.d_wdata;
          end
          acc_d.err = access_err(acc_d.we, acc_d.f3, acc_d.addr);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Writes and faulted accesses report zero read data.
        rdata_d = (acc_q.we || acc_q.err) ? '0 : bus.mem_rdata;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode only from registered state, so reset zeroes them at once.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_f3    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_ack    = 1'b0;
    bus.if_err    = 1'b0;
    bus.if_rdata  = '0;
    bus.d_ack     = 1'b0;
    bus.d_err     = 1'b0;
    bus.d_rdata   = '0;
    if (state_q == ST_ISSUE) begin
      bus.mem_rd    = ~acc_q.err & ~acc_q.we;
      bus.mem_wr    = ~acc_q.err & acc_q.we;
      bus.mem_f3    = acc_q.f3;
      bus.mem_addr  = acc_q.addr;
      bus.mem_wdata = acc_q.wdata;
    end
    if (state_q == ST_DONE) begin
      if (acc_q.id == ID_DATA) begin
        bus.d_ack   = 1'b1;
        bus.d_err   = acc_q.err;
        bus.d_rdata = rdata_q;
      end else begin
        bus.if_ack   = 1'b1;
        bus.if_err   = acc_q.err;
        bus.if_rdata = rdata_q;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Provides a 64-byte little-endian memory behind the shared port, a table of
// directed data accesses, multi-cycle sequences (priority, starvation, reset
// abort) and random accesses checked against a byte-array reference model.
// Expectations for starvation follow ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic mem_load;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] w;
    case (a / 4)
      0:       w = 32'd17;
      1:       w = 32'd9;
      4:       w = 32'hA5A5_A5A5;
      8:       w = 32'h0000_0033;
      default: w = 32'd0;
    endcase
    return w[8*(a%4) +: 8];
  endfunction

  // Memory environment: combinational read, write on clock edge.
  logic [7:0] env_mem [64];
  logic [7:0] rb0, rb1, rb2, rb3;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= init_byte(i);
    end else if (bus.mem_wr) begin
      env_mem[bus.mem_addr] <= bus.mem_wdata[7:0];
      if (bus.mem_f3[1:0] != 2'b00) env_mem[bus.mem_addr + 6'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_f3[1:0] == 2'b10) begin
        env_mem[bus.mem_addr + 6'd2] <= bus.mem_wdata[23:16];
        env_mem[bus.mem_addr + 6'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  assign rb0 = env_mem[bus.mem_addr];
  assign rb1 = env_mem[bus.mem_addr + 6'd1];
  assign rb2 = env_mem[bus.mem_addr + 6'd2];
  assign rb3 = env_mem[bus.mem_addr + 6'd3];

  always_comb begin
    case (bus.mem_f3)
      3'b000:  bus.mem_rdata = {{24{rb0[7]}}, rb0};
      3'b001:  bus.mem_rdata = {{16{rb1[7]}}, rb1, rb0};
      3'b010:  bus.mem_rdata = {rb3, rb2, rb1, rb0};
      3'b100:  bus.mem_rdata = {24'd0, rb0};
      3'b101:  bus.mem_rdata = {16'd0, rb1, rb0};
      default: bus.mem_rdata = 32'd0;
    endcase
  end

  // Reference model: plain byte array and size/alignment arithmetic.
  int ref_mem [64];

  function automatic int ref_size(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    if (f3 == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input int addr);
    int sz;
    sz = ref_size(we, f3);
    if (sz == 0) return 1'b1;
    if (addr % sz != 0) return 1'b1;
    return (addr + sz - 1 > 63);
  endfunction

  function automatic logic [31:0] ref_read(input logic [2:0] f3, input int addr);
    int     sz;
    longint v;
    sz = ref_size(1'b0, f3);
    v  = 0;
    for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[addr + i]);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic ref_write(input logic [2:0] f3, input int addr, input logic [31:0] wdata);
    int sz;
    sz = ref_size(1'b1, f3);
    for (int i = 0; i < sz; i++) ref_mem[addr + i] = int'((wdata >> (8 * i)) & 32'hFF);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One data access; expects strobe in cycle 1 and ack in cycle 2 after sampling.
  task automatic run_data(input string name, input logic we, input logic [2:0] f3,
                          input logic [5:0] addr, input logic [31:0] wdata, input logic drop,
                          input logic exp_err, input logic [31:0] exp_rdata);
    int          ack_cyc, rd_mask, wr_mask;
    logic        got_err, fields_ok, saw_if;
    logic [31:0] got_rdata;
    ack_cyc = -1; rd_mask = 0; wr_mask = 0;
    got_err = 1'b0; got_rdata = '0; fields_ok = 1'b1; saw_if = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_f3 = f3; bus.d_addr = addr; bus.d_wdata = wdata;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (drop && cyc == 1) begin
        // Request withdrawn and fields scrambled: the latched copy must be used.
        bus.d_req = 1'b0; bus.d_we = ~we; bus.d_f3 = ~f3; bus.d_addr = ~addr;
        bus.d_wdata = ~wdata;
      end
      if (bus.mem_rd) rd_mask |= (1 << cyc);
      if (bus.mem_wr) wr_mask |= (1 << cyc);
      if ((bus.mem_rd || bus.mem_wr) && (bus.mem_addr != addr || bus.mem_f3 != f3 ||
          (we && bus.mem_wdata != wdata))) fields_ok = 1'b0;
      if (bus.if_ack) saw_if = 1'b1;
      if (bus.d_ack) begin
        ack_cyc = cyc; got_err = bus.d_err; got_rdata = bus.d_rdata;
        break;
      end
    end
    bus.d_req = 1'b0;
    chk({name, " ack cycle"}, ack_cyc, 32'd2);
    chk({name, " err"}, 32'(got_err), 32'(exp_err));
    chk({name, " rdata"}, got_rdata, exp_rdata);
    chk({name, " mem_rd cycles"}, rd_mask, (!exp_err && !we) ? 32'd2 : 32'd0);
    chk({name, " mem_wr cycles"}, wr_mask, (!exp_err && we) ? 32'd2 : 32'd0);
    chk({name, " mem fields"}, 32'(fields_ok), 32'd1);
    chk({name, " stray if_ack"}, 32'(saw_if), 32'd0);
  endtask

  task automatic run_fetch(input string name, input logic [5:0] addr,
                           input logic exp_err, input logic [31:0] exp_rdata);
    int          ack_cyc, rd_mask;
    logic        got_err, fields_ok, saw_d;
    logic [31:0] got_rdata;
    ack_cyc = -1; rd_mask = 0; got_err = 1'b0; got_rdata = '0; fields_ok = 1'b1; saw_d = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = addr;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (bus.mem_rd) rd_mask |= (1 << cyc);
      if (bus.mem_wr) fields_ok = 1'b0;
      if (bus.mem_rd && (bus.mem_addr != addr || bus.mem_f3 != LOAD_LW)) fields_ok = 1'b0;
      if (bus.d_ack) saw_d = 1'b1;
      if (bus.if_ack) begin
        ack_cyc = cyc; got_err = bus.if_err; got_rdata = bus.if_rdata;
        break;
      end
    end
    bus.if_req = 1'b0;
    chk({name, " ack cycle"}, ack_cyc, 32'd2);
    chk({name, " err"}, 32'(got_err), 32'(exp_err));
    chk({name, " rdata"}, got_rdata, exp_rdata);
    chk({name, " mem_rd cycles"}, rd_mask, exp_err ? 32'd0 : 32'd2);
    chk({name, " mem fields"}, 32'(fields_ok), 32'd1);
    chk({name, " stray d_ack"}, 32'(saw_d), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        drop;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d_cyc, i_cyc, n_dack, last_dack, dack_before;
    logic [31:0] d_dat, i_dat, word16;
    logic        saw_ack;

    vecs[0]  = '{"lw0",      1'b0, LOAD_LW,  6'd0,  32'd0,         1'b0, 1'b0, 32'd17};
    vecs[1]  = '{"sw12",     1'b1, STORE_SW, 6'd12, 32'hDEADBEEF,  1'b0, 1'b0, 32'd0};
    vecs[2]  = '{"lw12",     1'b0, LOAD_LW,  6'd12, 32'd0,         1'b0, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{"lb15",     1'b0, LOAD_LB,  6'd15, 32'd0,         1'b0, 1'b0, 32'hFFFFFFDE};
    vecs[4]  = '{"lbu15",    1'b0, LOAD_LBU, 6'd15, 32'd0,         1'b0, 1'b0, 32'h000000DE};
    vecs[5]  = '{"lh14drop", 1'b0, LOAD_LH,  6'd14, 32'd0,         1'b1, 1'b0, 32'hFFFFDEAD};
    vecs[6]  = '{"lw6",      1'b0, LOAD_LW,  6'd6,  32'd0,         1'b0, 1'b1, 32'd0};
    vecs[7]  = '{"lw62",     1'b0, LOAD_LW,  6'd62, 32'd0,         1'b0, 1'b1, 32'd0};
    vecs[8]  = '{"sh9",      1'b1, STORE_SH, 6'd9,  32'h1234,      1'b0, 1'b1, 32'd0};
    vecs[9]  = '{"s_undef",  1'b1, 3'b011,   6'd0,  32'hFFFF,      1'b0, 1'b1, 32'd0};
    vecs[10] = '{"lw4",      1'b0, LOAD_LW,  6'd4,  32'd0,         1'b0, 1'b0, 32'd9};

    for (int i = 0; i < 64; i++) ref_mem[i] = int'(init_byte(i));

    rst_n = 1'b0; mem_load = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_f3 = '0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({busy, bus.if_ack, bus.if_err, |bus.if_rdata, bus.d_ack, bus.d_err,
        |bus.d_rdata, bus.mem_rd, bus.mem_wr, |bus.mem_f3, |bus.mem_addr, |bus.mem_wdata}),
        32'd0);
    mem_load = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_data(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].drop,
               vecs[i].exp_err, vecs[i].exp_rdata);
      if (vecs[i].we && !vecs[i].exp_err) ref_write(vecs[i].f3, int'(vecs[i].addr), vecs[i].wdata);
    end

    // Simultaneous fetch and data: data first, fetch one slot later.
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 6'd32;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_f3 = LOAD_LW; bus.d_addr = 6'd4;
    d_cyc = -1; i_cyc = -1; d_dat = '0; i_dat = '0;
    for (int cyc = 1; cyc <= 12 && (d_cyc < 0 || i_cyc < 0); cyc++) begin
      @(negedge clk);
      if (bus.d_ack && d_cyc < 0) begin d_cyc = cyc; d_dat = bus.d_rdata; bus.d_req = 1'b0; end
      if (bus.if_ack && i_cyc < 0) begin i_cyc = cyc; i_dat = bus.if_rdata; bus.if_req = 1'b0; end
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    chk("prio d_ack cycle", d_cyc, 32'd2);
    chk("prio d_rdata", d_dat, 32'd9);
    chk("prio if_ack cycle", i_cyc, 32'd5);
    chk("prio if_rdata", i_dat, 32'h33);

    // Data held back-to-back while a fetch waits.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_f3 = LOAD_LW; bus.d_addr = 6'd0;
    bus.if_req = 1'b1; bus.if_addr = 6'd32;
    n_dack = 0; last_dack = 0; i_cyc = -1; dack_before = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus.d_ack) begin n_dack++; last_dack = cyc; end
      if (bus.if_ack) begin i_cyc = cyc; dack_before = n_dack; break; end
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    chk("starve d_acks before if_ack", dack_before, 32'd4);
    chk("starve if_ack gap", i_cyc - last_dack, 32'd3);
`else
    chk("strict no if_ack", i_cyc, 32'hFFFF_FFFF);
    chk("strict d_ack count", n_dack, 32'd10);
`endif
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("drain to idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_f3 = STORE_SW; bus.d_addr = 6'd16;
    bus.d_wdata = 32'h1;
    @(posedge clk);
    #2;
    chk("abort mem_wr in issue", 32'(bus.mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_wr falls", 32'(bus.mem_wr), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_ack) saw_ack = 1'b1;
    end
    bus.d_req = 1'b0; rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.d_ack) saw_ack = 1'b1;
    end
    chk("abort no d_ack", 32'(saw_ack), 32'd0);
    word16 = {env_mem[19], env_mem[18], env_mem[17], env_mem[16]};
    chk("abort word16 unchanged", word16, 32'hA5A5_A5A5);
    run_data("lw16 after reset", 1'b0, LOAD_LW, 6'd16, 32'd0, 1'b0, 1'b0, 32'hA5A5_A5A5);

    // Random accesses against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [5:0]  a;
      logic [2:0]  f3;
      logic        we, e;
      logic [31:0] wd, r;
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) begin
        e = ref_err(1'b0, LOAD_LW, int'(a));
        r = e ? 32'd0 : ref_read(LOAD_LW, int'(a));
        run_fetch($sformatf("rnd%0d fetch", k), a, e, r);
      end else begin
        we = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        e  = ref_err(we, f3, int'(a));
        r  = (e || we) ? 32'd0 : ref_read(f3, int'(a));
        run_data($sformatf("rnd%0d data", k), we, f3, a, wd, 1'($urandom_range(0, 1)), e, r);
        if (we && !e) ref_write(f3, int'(a), wd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
